// File: rtl/write_back_queue.sv
// Write-back queue merging MEM and ALU results into a single register-file write port.
// Optional operand bypass search is compiled in with `define WBQ_BYPASS_EN.
module write_back_queue #(
  parameter int WordWidth               = 32,
  parameter int Def_RegisterSelectWidth = 5,
  parameter int Depth                   = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_MEMWriteEnable,
  input  logic [Def_RegisterSelectWidth-1:0] in_MEMWriteRegisterNumber,
  input  logic [WordWidth-1:0]               in_MEMWriteBus,
  input  logic                               in_ALUWriteEnable,
  input  logic [Def_RegisterSelectWidth-1:0] in_ALUWriteRegisterNumber,
  input  logic [WordWidth-1:0]               in_ALUWriteBus,
  output logic                               out_Stall,
  output logic                               out_WriteEnable,
  output logic [Def_RegisterSelectWidth-1:0] out_WriteRegisterNumber,
  output logic [WordWidth-1:0]               out_WriteBus,
  input  logic [Def_RegisterSelectWidth-1:0] in_LeftReadRegisterNumber,
  input  logic [Def_RegisterSelectWidth-1:0] in_RightReadRegisterNumber,
  output logic                               out_LeftHit,
  output logic [WordWidth-1:0]               out_LeftBus,
  output logic                               out_RightHit,
  output logic [WordWidth-1:0]               out_RightBus
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic [Def_RegisterSelectWidth-1:0] regnum_q [Depth];
  logic [WordWidth-1:0]               data_q   [Depth];
  logic [PtrW-1:0]                    head, tail, alu_slot;
  logic [CntW-1:0]                    count, free_slots;
  logic                               mem_push, alu_push, pop;

  // Two free slots are required so a dual request never has to be split.
  assign free_slots = CntW'(Depth) - count;
  assign out_Stall  = free_slots < CntW'(2);
  assign mem_push   = in_MEMWriteEnable & ~out_Stall;
  assign alu_push   = in_ALUWriteEnable & ~out_Stall;
  assign pop        = count != '0;
  assign alu_slot   = mem_push ? tail + PtrW'(1) : tail;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (mem_push) begin
        regnum_q[tail] <= in_MEMWriteRegisterNumber;
        data_q[tail]   <= in_MEMWriteBus;
      end
      if (alu_push) begin
        regnum_q[alu_slot] <= in_ALUWriteRegisterNumber;
        data_q[alu_slot]   <= in_ALUWriteBus;
      end
      tail  <= tail + PtrW'(mem_push) + PtrW'(alu_push);
      head  <= head + PtrW'(pop);
      count <= count + CntW'(mem_push) + CntW'(alu_push) - CntW'(pop);
    end
  end

  assign out_WriteEnable         = pop;
  assign out_WriteRegisterNumber = pop ? regnum_q[head] : '0;
  assign out_WriteBus            = pop ? data_q[head] : '0;

`ifdef WBQ_BYPASS_EN
  // Walk oldest to youngest so later matches override; inputs are youngest of all.
  always_comb begin
    logic [PtrW-1:0] idx;
    out_LeftHit  = 1'b0;
    out_LeftBus  = '0;
    out_RightHit = 1'b0;
    out_RightBus = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      idx = head + PtrW'(i);
      if (CntW'(i) < count) begin
        if (regnum_q[idx] == in_LeftReadRegisterNumber) begin
          out_LeftHit = 1'b1;
          out_LeftBus = data_q[idx];
        end
        if (regnum_q[idx] == in_RightReadRegisterNumber) begin
          out_RightHit = 1'b1;
          out_RightBus = data_q[idx];
        end
      end
    end
    if (mem_push && in_MEMWriteRegisterNumber == in_LeftReadRegisterNumber) begin
      out_LeftHit = 1'b1;
      out_LeftBus = in_MEMWriteBus;
    end
    if (mem_push && in_MEMWriteRegisterNumber == in_RightReadRegisterNumber) begin
      out_RightHit = 1'b1;
      out_RightBus = in_MEMWriteBus;
    end
    if (alu_push && in_ALUWriteRegisterNumber == in_LeftReadRegisterNumber) begin
      out_LeftHit = 1'b1;
      out_LeftBus = in_ALUWriteBus;
    end
    if (alu_push && in_ALUWriteRegisterNumber == in_RightReadRegisterNumber) begin
      out_RightHit = 1'b1;
      out_RightBus = in_ALUWriteBus;
    end
  end
`else
  logic unused_read_numbers;
  assign unused_read_numbers = ^{in_LeftReadRegisterNumber, in_RightReadRegisterNumber};
  assign out_LeftHit  = 1'b0;
  assign out_LeftBus  = '0;
  assign out_RightHit = 1'b0;
  assign out_RightBus = '0;
`endif

endmodule

// File: tb/tb_write_back_queue.sv
// Directed self-checking bench for write_back_queue (Depth = 4).
module tb_write_back_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_en, alu_en;
  logic [4:0]  mem_reg, alu_reg, left_reg, right_reg;
  logic [31:0] mem_bus, alu_bus;
  logic        stall, we, left_hit, right_hit;
  logic [4:0]  wr_reg;
  logic [31:0] wr_bus, left_bus, right_bus;

  int checks = 0;
  int errors = 0;

  write_back_queue #(.WordWidth(32), .Def_RegisterSelectWidth(5), .Depth(4)) dut (
    .clock(clock), .reset(reset),
    .in_MEMWriteEnable(mem_en), .in_MEMWriteRegisterNumber(mem_reg), .in_MEMWriteBus(mem_bus),
    .in_ALUWriteEnable(alu_en), .in_ALUWriteRegisterNumber(alu_reg), .in_ALUWriteBus(alu_bus),
    .out_Stall(stall), .out_WriteEnable(we),
    .out_WriteRegisterNumber(wr_reg), .out_WriteBus(wr_bus),
    .in_LeftReadRegisterNumber(left_reg), .in_RightReadRegisterNumber(right_reg),
    .out_LeftHit(left_hit), .out_LeftBus(left_bus),
    .out_RightHit(right_hit), .out_RightBus(right_bus)
  );

  always #5 clock = ~clock;

  task automatic idle_inputs();
    mem_en = 0; mem_reg = 0; mem_bus = 0;
    alu_en = 0; alu_reg = 0; alu_bus = 0;
    left_reg = 0; right_reg = 0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1;
    mem_en = 1; mem_reg = 5'd7; mem_bus = 32'hDEAD;
    alu_en = 1; alu_reg = 5'd8; alu_bus = 32'hBEEF;
    @(negedge clock);
    reset = 0;
    idle_inputs();
    #1;
    checks++;
    if (we !== 1'b0 || stall !== 1'b0 || wr_reg !== 5'd0 || wr_bus !== 32'd0 ||
        left_hit !== 1'b0 || right_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: we=%b stall=%b reg=%0d bus=%h lh=%b rh=%b, expected all 0",
               we, stall, wr_reg, wr_bus, left_hit, right_hit);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clock); #1;
      checks++;
      if (we !== 1'b0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle%0d: we=%b stall=%b, expected 0 0", c, we, stall);
      end
    end
  endtask

  task automatic test_single_alu();
    @(negedge clock);
    alu_en = 1; alu_reg = 5'd3; alu_bus = 32'h0000_00A5;
    @(negedge clock);
    idle_inputs(); #1;
    checks++;
    if (we !== 1'b1 || wr_reg !== 5'd3 || wr_bus !== 32'hA5 || stall !== 1'b0) begin
      errors++;
      $display("FAIL single_alu_write: we=%b reg=%0d bus=%h stall=%b, expected 1 3 a5 0",
               we, wr_reg, wr_bus, stall);
    end
    @(negedge clock); #1;
    checks++;
    if (we !== 1'b0 || wr_bus !== 32'd0) begin
      errors++;
      $display("FAIL single_alu_drained: we=%b bus=%h, expected 0 0", we, wr_bus);
    end
  endtask

  task automatic test_dual_same_cycle();
    @(negedge clock);
    mem_en = 1; mem_reg = 5'd1; mem_bus = 32'h11;
    alu_en = 1; alu_reg = 5'd2; alu_bus = 32'h22;
    @(negedge clock);
    idle_inputs(); #1;
    checks++;
    if (we !== 1'b1 || wr_reg !== 5'd1 || wr_bus !== 32'h11 || dut.count !== 3'd2) begin
      errors++;
      $display("FAIL dual_first: we=%b reg=%0d bus=%h count=%0d, expected 1 1 11 2",
               we, wr_reg, wr_bus, dut.count);
    end
    @(negedge clock); #1;
    checks++;
    if (we !== 1'b1 || wr_reg !== 5'd2 || wr_bus !== 32'h22 || dut.count !== 3'd1) begin
      errors++;
      $display("FAIL dual_second: we=%b reg=%0d bus=%h count=%0d, expected 1 2 22 1",
               we, wr_reg, wr_bus, dut.count);
    end
    @(negedge clock); #1;
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL dual_drained: we=%b, expected 0", we);
    end
  endtask

  task automatic test_back_to_back();
    // Count before each edge goes 0,2,3,2,3,2: stall pattern below, pairs accepted at cycles 0,1,3,5.
    logic        exp_stall [6] = '{0, 0, 1, 0, 1, 0};
    logic [4:0]  exp_reg [8];
    logic [31:0] exp_bus [8];
    int pair = 0;
    int got  = 0;
    int cyc  = 0;
    for (int k = 0; k < 4; k++) begin
      exp_reg[2*k]   = 5'(10 + 2*k);  exp_bus[2*k]   = 32'h100 + 32'(k);
      exp_reg[2*k+1] = 5'(11 + 2*k);  exp_bus[2*k+1] = 32'h200 + 32'(k);
    end
    while ((pair < 4 || we === 1'b1) && cyc < 40) begin
      @(negedge clock);
      if (pair < 4) begin
        mem_en = 1; mem_reg = exp_reg[2*pair];   mem_bus = exp_bus[2*pair];
        alu_en = 1; alu_reg = exp_reg[2*pair+1]; alu_bus = exp_bus[2*pair+1];
      end else begin
        idle_inputs();
      end
      #1;
      if (cyc < 6) begin
        checks++;
        if (stall !== exp_stall[cyc]) begin
          errors++;
          $display("FAIL b2b_stall_cycle%0d: stall=%b, expected %b", cyc, stall, exp_stall[cyc]);
        end
      end
      if (we === 1'b1) begin
        checks++;
        if (got >= 8 || wr_reg !== exp_reg[got] || wr_bus !== exp_bus[got]) begin
          errors++;
          $display("FAIL b2b_write%0d: reg=%0d bus=%h, expected reg=%0d bus=%h",
                   got, wr_reg, wr_bus, exp_reg[got % 8], exp_bus[got % 8]);
        end
        got++;
      end
      if (pair < 4 && stall === 1'b0) pair++;
      cyc++;
    end
    idle_inputs();
    checks++;
    if (got !== 8 || cyc >= 40) begin
      errors++;
      $display("FAIL b2b_total: writes=%0d cycles=%0d, expected 8 writes within 40", got, cyc);
    end
  endtask

  task automatic test_bypass();
    @(negedge clock);
    mem_en = 1; mem_reg = 5'd5; mem_bus = 32'h1;
    @(negedge clock);
    idle_inputs();
    alu_en = 1; alu_reg = 5'd5; alu_bus = 32'h2;
    left_reg = 5'd5; right_reg = 5'd9;
    #1;
    checks++;
`ifdef WBQ_BYPASS_EN
    if (left_hit !== 1'b1 || left_bus !== 32'h2 || right_hit !== 1'b0 || right_bus !== 32'd0) begin
      errors++;
      $display("FAIL bypass_alu_over_queue: lh=%b lb=%h rh=%b rb=%h, expected 1 2 0 0",
               left_hit, left_bus, right_hit, right_bus);
    end
`else
    if (left_hit !== 1'b0 || left_bus !== 32'd0 || right_hit !== 1'b0 || right_bus !== 32'd0) begin
      errors++;
      $display("FAIL bypass_disabled: lh=%b lb=%h rh=%b rb=%h, expected 0 0 0 0",
               left_hit, left_bus, right_hit, right_bus);
    end
`endif
    @(negedge clock);
    alu_en = 0;
    right_reg = 5'd5;
    #1;
    checks++;
`ifdef WBQ_BYPASS_EN
    if (right_hit !== 1'b1 || right_bus !== 32'h2) begin
      errors++;
      $display("FAIL bypass_queue_entry: rh=%b rb=%h, expected 1 2", right_hit, right_bus);
    end
`else
    if (right_hit !== 1'b0 || right_bus !== 32'd0) begin
      errors++;
      $display("FAIL bypass_queue_disabled: rh=%b rb=%h, expected 0 0", right_hit, right_bus);
    end
`endif
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_mid_reset();
    @(negedge clock);
    mem_en = 1; mem_reg = 5'd20; mem_bus = 32'hA;
    alu_en = 1; alu_reg = 5'd21; alu_bus = 32'hB;
    @(negedge clock);
    mem_reg = 5'd22; mem_bus = 32'hC;
    alu_reg = 5'd23; alu_bus = 32'hD;
    @(negedge clock);
    idle_inputs(); #1;
    checks++;
    if (dut.count !== 3'd3 || stall !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_setup: count=%0d stall=%b, expected 3 1", dut.count, stall);
    end
    reset = 1;
    @(negedge clock);
    reset = 0; #1;
    checks++;
    if (dut.count !== 3'd0 || we !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_cleared: count=%0d we=%b stall=%b, expected 0 0 0",
               dut.count, we, stall);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock); #1;
      checks++;
      if (we !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_no_write%0d: we=%b, expected 0", c, we);
      end
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_alu();
    test_dual_same_cycle();
    test_back_to_back();
    test_bypass();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_back_queue.md
WRITE_BACK_QUEUE -- requirements
Module: write_back_queue

Interface
REQ-001 Parameter WordWidth, default 32: data width of every write bus.
REQ-002 Parameter Def_RegisterSelectWidth, default 5: register-number width.
REQ-003 Parameter Depth, default 4: queue entries; power of two, minimum 2.
REQ-004 Port clock, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Ports in_MEMWriteEnable, in_MEMWriteRegisterNumber, in_MEMWriteBus, inputs, 1/RS/WW: load-result write request; older of the two sources.
REQ-007 Ports in_ALUWriteEnable, in_ALUWriteRegisterNumber, in_ALUWriteBus, inputs, 1/RS/WW: ALU-result write request; younger of the two sources.
REQ-008 Port out_Stall, output, 1: queue cannot accept this cycle; upstream holds its requests.
REQ-009 Ports out_WriteEnable, out_WriteRegisterNumber, out_WriteBus, outputs, 1/RS/WW: drive the register-file write port.
REQ-010 Ports in_LeftReadRegisterNumber, in_RightReadRegisterNumber, inputs, RS: operand numbers being read from the register file.
REQ-011 Ports out_LeftHit, out_LeftBus, out_RightHit, out_RightBus, outputs, 1/WW: bypass result per read port.

Function
REQ-012 Storage is a circular buffer of Depth entries {regnum, data}, with head pointer, tail pointer and an occupancy count in the range 0..Depth.
REQ-013 Pointers wrap modulo Depth; the full/empty decision uses the count only.
REQ-014 out_Stall is asserted combinationally when (Depth - count) < 2, independent of the request enables.
REQ-015 When out_Stall is 0, each asserted source enqueues one entry at the edge; when both are asserted, MEM goes to tail and ALU to tail+1.
REQ-016 When out_Stall is 1, the inputs are ignored; no entry is lost, because upstream holds its requests.
REQ-017 Two requests to the same register number are both enqueued in order, without coalescing.
REQ-018 out_WriteEnable equals (count != 0); out_WriteRegisterNumber and out_WriteBus are driven combinationally from the head entry, and both are 0 when the queue is empty.
REQ-019 When the queue is non-empty, the head is dequeued every cycle; the register file always accepts the write.
REQ-020 Enqueue and dequeue in the same cycle: count_next = count + enqueued - dequeued.
REQ-021 Latency: a request accepted at edge N is written to the register file at edge N+1 at the earliest, and at most at edge N+Depth.
REQ-022 Bypass per read port: hit when the read number matches a valid queue entry or an asserted, accepted input.
REQ-023 Bypass priority runs youngest first: ALU input, then MEM input, then queue entries from tail-1 back to head.
REQ-024 Bypass outputs are combinational; out_*Bus is 0 when out_*Hit is 0.

Reset
REQ-025 While reset is 1 at an edge: count, head and tail are cleared to 0, and all entries are discarded, including mid-operation entries.
REQ-026 After that edge, out_WriteEnable is 0, out_WriteRegisterNumber and out_WriteBus are 0, out_Stall is 0, and both hits are 0.
REQ-027 Requests presented during a reset cycle are not enqueued.

Configuration
REQ-028 Macro WBQ_BYPASS_EN, when defined, compiles in the bypass search logic of REQ-022 to REQ-024.
REQ-029 Without WBQ_BYPASS_EN, the bypass ports remain, out_LeftHit and out_RightHit are tied to 0, and the buses are tied to 0; queue behaviour is unchanged.

Verification
REQ-030 Reset then idle: after the reset edge, out_WriteEnable = 0 and out_Stall = 0, and they stay so for 10 cycles.
REQ-031 Single ALU write of r3 = 0x0000_00A5: the next cycle shows out_WriteEnable = 1, out_WriteRegisterNumber = 3 and out_WriteBus = 0xA5; the following cycle shows out_WriteEnable = 0.
REQ-032 MEM r1 = 0x11 and ALU r2 = 0x22 in the same cycle: the writes occur r1 then r2 on consecutive cycles, and count peaks at 2.
REQ-033 Dual requests every cycle with Depth = 4: out_Stall asserts once count reaches 3; the held requests are accepted after drain, and every value arrives once, in order.
REQ-034 Bypass with WBQ_BYPASS_EN: queue holds r5 = 0x1 with ALU input r5 = 0x2, and Left reads r5: out_LeftHit = 1 and out_LeftBus = 0x2; without the macro, hit = 0.
REQ-035 Reset mid-operation with 3 entries queued: after the reset edge, count = 0 and no further writes are issued.
